// File: rtl/regfile_pkg.sv
// Shared register-file constants and the register-index type used by decode,
// writeback and the register file itself.
package regfile_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned AW_DEF   = $clog2(NREG_DEF);

  typedef logic [AW_DEF-1:0] reg_idx_t;

  // Index width for an n-entry file; a single-entry file still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Outstanding-write scoreboard: one busy bit per GPR plus one for HI/LO, with
// flush > issue-set > write-clear priority and same-cycle write masking on reads.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned NRD  = 4,
  parameter int unsigned NWR  = 2,
  parameter int unsigned AW   = idx_width(NREG_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_dst,
  input  logic              iss_gpr,
  input  logic              iss_hilo,
  input  logic              flush,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] wa,
  input  logic [1:0]        hilo_we,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD-1:0]    rd_busy,
  output logic              hilo_busy
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            hilo_bit;
  logic            hilo_nxt;
  logic            set_j;
  logic            clr_j;

  always_comb begin
    busy_nxt = busy;
    set_j    = 1'b0;
    clr_j    = 1'b0;
    for (int unsigned j = 0; j < NREG; j++) begin
      clr_j = 1'b0;
      for (int unsigned i = 0; i < NWR; i++) begin
        if (we[i] && (wa[i*AW +: AW] == AW'(j))) clr_j = 1'b1;
      end
      set_j = iss_valid && iss_gpr && (iss_dst == AW'(j)) && (j != 0);
      if (flush)      busy_nxt[j] = 1'b0;
      else if (set_j) busy_nxt[j] = 1'b1;
      else if (clr_j) busy_nxt[j] = 1'b0;
    end
  end

  always_comb begin
    hilo_nxt = hilo_bit;
    if (flush)                       hilo_nxt = 1'b0;
    else if (iss_valid && iss_hilo)  hilo_nxt = 1'b1;
    else if (|hilo_we)               hilo_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      hilo_bit <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      hilo_bit <= hilo_nxt;
    end
  end

  logic [AW-1:0] a;
  logic          hit;

  // A write retiring this cycle already hides the busy bit from readers.
  always_comb begin
    rd_busy = '0;
    a       = '0;
    hit     = 1'b0;
    for (int unsigned k = 0; k < NRD; k++) begin
      a   = ra[k*AW +: AW];
      hit = 1'b0;
      for (int unsigned i = 0; i < NWR; i++) begin
        if (we[i] && (wa[i*AW +: AW] == a)) hit = 1'b1;
      end
      if (int'(a) < int'(NREG)) rd_busy[k] = busy[a] & ~hit;
    end
  end

  assign hilo_busy = hilo_bit & ~(|hilo_we);

endmodule

// File: rtl/regfile_sb.sv
// Multi-ported GPR file with HI/LO, zero-latency write-through bypass and an
// attached outstanding-write scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned NRD  = 4,
  parameter int unsigned NWR  = 2,
  localparam int unsigned AW  = idx_width(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic [1:0]          hilo_we,
  input  logic [XLEN-1:0]     hi_wd,
  input  logic [XLEN-1:0]     lo_wd,
  output logic [XLEN-1:0]     hi_rd,
  output logic [XLEN-1:0]     lo_rd,
  output logic                hilo_busy,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_dst,
  input  logic                iss_gpr,
  input  logic                iss_hilo,
  input  logic                flush
);

  logic [XLEN-1:0] regs [NREG];
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  // Later ports are visited last, so the highest-indexed writer wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned j = 0; j < NREG; j++) regs[j] <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      for (int unsigned j = 1; j < NREG; j++) begin
        for (int unsigned i = 0; i < NWR; i++) begin
          if (we[i] && (wa[i*AW +: AW] == AW'(j))) regs[j] <= wd[i*XLEN +: XLEN];
        end
      end
      if (hilo_we[1]) hi <= hi_wd;
      if (hilo_we[0]) lo <= lo_wd;
    end
  end

  logic [AW-1:0]   a;
  logic [XLEN-1:0] v;

  always_comb begin
    rd = '0;
    a  = '0;
    v  = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      a = ra[k*AW +: AW];
      v = '0;
      if ((a != '0) && (int'(a) < int'(NREG))) begin
        v = regs[a];
        for (int unsigned i = 0; i < NWR; i++) begin
          if (we[i] && (wa[i*AW +: AW] == a)) v = wd[i*XLEN +: XLEN];
        end
      end
      rd[k*XLEN +: XLEN] = rst ? '0 : v;
    end
  end

  always_comb begin
    hi_rd = '0;
    lo_rd = '0;
    if (!rst) begin
      hi_rd = hilo_we[1] ? hi_wd : hi;
      lo_rd = hilo_we[0] ? lo_wd : lo;
    end
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD),
    .NWR  (NWR),
    .AW   (AW)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_dst   (iss_dst),
    .iss_gpr   (iss_gpr),
    .iss_hilo  (iss_hilo),
    .flush     (flush),
    .we        (we),
    .wa        (wa),
    .hilo_we   (hilo_we),
    .ra        (ra),
    .rd_busy   (rd_busy),
    .hilo_busy (hilo_busy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, reset/out-of-range
// sequences and randomized traffic against an array-based reference model.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int XLEN = 32;
  localparam int NRD  = 4;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd, rd2;
  logic [NRD-1:0]      rd_busy, rd_busy2;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   wa;
  logic [NWR*XLEN-1:0] wd;
  logic [1:0]          hilo_we;
  logic [XLEN-1:0]     hi_wd, lo_wd, hi_rd, lo_rd, hi_rd2, lo_rd2;
  logic                hilo_busy, hilo_busy2;
  logic                iss_valid, iss_gpr, iss_hilo, flush;
  logic [AW-1:0]       iss_dst;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(32), .NREG(32), .NRD(4), .NWR(2)) dut (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rd_busy(rd_busy),
    .we(we), .wa(wa), .wd(wd), .hilo_we(hilo_we), .hi_wd(hi_wd), .lo_wd(lo_wd),
    .hi_rd(hi_rd), .lo_rd(lo_rd), .hilo_busy(hilo_busy), .iss_valid(iss_valid),
    .iss_dst(iss_dst), .iss_gpr(iss_gpr), .iss_hilo(iss_hilo), .flush(flush));

  // Partially populated file: indices 24..31 are out of range.
  regfile_sb #(.XLEN(32), .NREG(24), .NRD(4), .NWR(2)) dut24 (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd2), .rd_busy(rd_busy2),
    .we(we), .wa(wa), .wd(wd), .hilo_we(hilo_we), .hi_wd(hi_wd), .lo_wd(lo_wd),
    .hi_rd(hi_rd2), .lo_rd(lo_rd2), .hilo_busy(hilo_busy2), .iss_valid(iss_valid),
    .iss_dst(iss_dst), .iss_gpr(iss_gpr), .iss_hilo(iss_hilo), .flush(flush));

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_r [32];
  bit          m_busy [32];
  bit          m_hb;
  logic [31:0] m_hi, m_lo;

  function automatic reg_idx_t wa_of(input int i);
    return wa[i*AW +: AW];
  endfunction
  function automatic logic [31:0] wd_of(input int i);
    return wd[i*XLEN +: XLEN];
  endfunction
  function automatic reg_idx_t ra_of(input int k);
    return ra[k*AW +: AW];
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 32; j++) begin
      m_r[j] = 0;
      m_busy[j] = 0;
    end
    m_hb = 0; m_hi = 0; m_lo = 0;
  endtask

  function automatic logic [31:0] exp_rd(input reg_idx_t a);
    if (a == 0) return 0;
    for (int i = NWR - 1; i >= 0; i--)
      if (we[i] && wa_of(i) == a) return wd_of(i);
    return m_r[a];
  endfunction

  function automatic logic exp_busy(input reg_idx_t a);
    for (int i = 0; i < NWR; i++)
      if (we[i] && wa_of(i) == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_commit();
    for (int i = 0; i < NWR; i++)
      if (we[i] && wa_of(i) != 0) m_r[wa_of(i)] = wd_of(i);
    if (hilo_we[1]) m_hi = hi_wd;
    if (hilo_we[0]) m_lo = lo_wd;
    if (flush) begin
      for (int j = 0; j < 32; j++) m_busy[j] = 0;
      m_hb = 0;
    end else begin
      for (int i = 0; i < NWR; i++)
        if (we[i]) m_busy[wa_of(i)] = 0;
      if (hilo_we != 0) m_hb = 0;
      if (iss_valid && iss_gpr && iss_dst != 0) m_busy[iss_dst] = 1;
      if (iss_valid && iss_hilo) m_hb = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle();
    we = 0; wa = 0; wd = 0; hilo_we = 0; hi_wd = 0; lo_wd = 0;
    iss_valid = 0; iss_dst = 0; iss_gpr = 0; iss_hilo = 0; flush = 0; ra = 0;
  endtask

  task automatic set_ra_all(input reg_idx_t a);
    for (int k = 0; k < NRD; k++) ra[k*AW +: AW] = a;
  endtask

  task automatic check_model(input string tag);
    for (int k = 0; k < NRD; k++) begin
      chk($sformatf("%s rd[%0d]", tag, k), rd[k*XLEN +: XLEN], exp_rd(ra_of(k)));
      chk($sformatf("%s rd_busy[%0d]", tag, k), 32'(rd_busy[k]), 32'(exp_busy(ra_of(k))));
    end
    chk({tag, " hi"}, hi_rd, hilo_we[1] ? hi_wd : m_hi);
    chk({tag, " lo"}, lo_rd, hilo_we[0] ? lo_wd : m_lo);
    chk({tag, " hilo_busy"}, 32'(hilo_busy), 32'(m_hb && hilo_we == 0));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  we;
    reg_idx_t    wa0;
    logic [31:0] wd0;
    reg_idx_t    wa1;
    logic [31:0] wd1;
    reg_idx_t    ra;
    logic [1:0]  hwe;
    logic [31:0] hi_wd;
    logic [31:0] lo_wd;
    logic        iv;
    reg_idx_t    dst;
    logic        ig;
    logic        ih;
    logic        fl;
    logic [31:0] e_rd;
    logic        e_busy;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic        e_hb;
  } vec_t;

  vec_t vt [$];

  initial begin
    //       we   wa0 wd0           wa1 wd1       ra hwe hi_wd     lo_wd     iv dst ig ih fl  e_rd          eb e_hi      e_lo      ehb
    vt.push_back('{2'b01, 5, 32'hDEADBEEF, 0, 0,          5, 0, 0,         0,        0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0,        0,        0});
    vt.push_back('{2'b00, 0, 0,            0, 0,          5, 0, 0,         0,        0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0,        0,        0});
    vt.push_back('{2'b11, 7, 32'h1111,     7, 32'h2222,   7, 0, 0,         0,        0, 0, 0, 0, 0, 32'h2222,     0, 0,        0,        0});
    vt.push_back('{2'b00, 0, 0,            0, 0,          7, 0, 0,         0,        0, 0, 0, 0, 0, 32'h2222,     0, 0,        0,        0});
    vt.push_back('{2'b01, 0, 32'hFFFFFFFF, 0, 0,          0, 0, 0,         0,        1, 0, 1, 0, 0, 0,            0, 0,        0,        0});
    vt.push_back('{2'b00, 0, 0,            0, 0,          0, 0, 0,         0,        0, 0, 0, 0, 0, 0,            0, 0,        0,        0});
    vt.push_back('{2'b00, 0, 0,            0, 0,          9, 0, 0,         0,        1, 9, 1, 0, 0, 0,            0, 0,        0,        0});
    vt.push_back('{2'b00, 0, 0,            0, 0,          9, 0, 0,         0,        0, 0, 0, 0, 0, 0,            1, 0,        0,        0});
    vt.push_back('{2'b01, 9, 32'h99,       0, 0,          9, 0, 0,         0,        0, 0, 0, 0, 0, 32'h99,       0, 0,        0,        0});
    vt.push_back('{2'b00, 0, 0,            0, 0,          9, 0, 0,         0,        0, 0, 0, 0, 0, 32'h99,       0, 0,        0,        0});
    vt.push_back('{2'b01, 9, 32'h9A,       0, 0,          9, 0, 0,         0,        1, 9, 1, 0, 0, 32'h9A,       0, 0,        0,        0});
    vt.push_back('{2'b00, 0, 0,            0, 0,          9, 0, 0,         0,        0, 0, 0, 0, 0, 32'h9A,       1, 0,        0,        0});
    vt.push_back('{2'b00, 0, 0,            0, 0,          9, 2, 32'hA5A5,  32'h1234, 0, 0, 0, 0, 0, 32'h9A,       1, 32'hA5A5, 0,        0});
    vt.push_back('{2'b00, 0, 0,            0, 0,          9, 0, 0,         0,        0, 0, 0, 0, 0, 32'h9A,       1, 32'hA5A5, 0,        0});
    vt.push_back('{2'b00, 0, 0,            0, 0,          9, 0, 0,         0,        1, 0, 0, 1, 0, 32'h9A,       1, 32'hA5A5, 0,        0});
    vt.push_back('{2'b00, 0, 0,            0, 0,          9, 0, 0,         0,        0, 0, 0, 0, 0, 32'h9A,       1, 32'hA5A5, 0,        1});
    vt.push_back('{2'b00, 0, 0,            0, 0,          9, 0, 0,         0,        0, 0, 0, 0, 1, 32'h9A,       1, 32'hA5A5, 0,        1});
    vt.push_back('{2'b00, 0, 0,            0, 0,          9, 0, 0,         0,        0, 0, 0, 0, 0, 32'h9A,       0, 32'hA5A5, 0,        0});
    vt.push_back('{2'b00, 0, 0,            0, 0,          9, 1, 32'hFFFF,  32'h77,   0, 0, 0, 0, 0, 32'h9A,       0, 32'hA5A5, 32'h77,   0});
    vt.push_back('{2'b00, 0, 0,            0, 0,          9, 0, 0,         0,        1, 9, 1, 1, 1, 32'h9A,       0, 32'hA5A5, 32'h77,   0});
    vt.push_back('{2'b00, 0, 0,            0, 0,          9, 0, 0,         0,        0, 0, 0, 0, 0, 32'h9A,       0, 32'hA5A5, 32'h77,   0});
  end

  initial begin
    idle();
    rst = 1'b1;
    model_reset();
    #3;
    for (int k = 0; k < NRD; k++) chk("reset rd", rd[k*XLEN +: XLEN], 0);
    chk("reset rd_busy", 32'(rd_busy), 0);
    chk("reset hi/lo", hi_rd | lo_rd, 0);
    #8 rst = 1'b0;

    // Directed table
    foreach (vt[n]) begin
      we = vt[n].we; wa = {vt[n].wa1, vt[n].wa0}; wd = {vt[n].wd1, vt[n].wd0};
      set_ra_all(vt[n].ra);
      hilo_we = vt[n].hwe; hi_wd = vt[n].hi_wd; lo_wd = vt[n].lo_wd;
      iss_valid = vt[n].iv; iss_dst = vt[n].dst; iss_gpr = vt[n].ig;
      iss_hilo = vt[n].ih; flush = vt[n].fl;
      #3;
      for (int k = 0; k < NRD; k++) begin
        chk($sformatf("vec%0d rd[%0d]", n, k), rd[k*XLEN +: XLEN], vt[n].e_rd);
        chk($sformatf("vec%0d rd_busy[%0d]", n, k), 32'(rd_busy[k]), 32'(vt[n].e_busy));
      end
      chk($sformatf("vec%0d hi", n), hi_rd, vt[n].e_hi);
      chk($sformatf("vec%0d lo", n), lo_rd, vt[n].e_lo);
      chk($sformatf("vec%0d hilo_busy", n), 32'(hilo_busy), 32'(vt[n].e_hb));
      tick();
    end

    // Out-of-range index on the 24-entry file
    idle();
    we = 2'b01; wa = {5'd0, 5'd30}; wd = {32'h0, 32'h00000BAD};
    iss_valid = 1; iss_gpr = 1; iss_dst = 30;
    set_ra_all(30);
    #3;
    chk("oor bypass rd", rd2[XLEN-1:0], 0);
    chk("oor bypass busy", 32'(rd_busy2), 0);
    tick();
    idle();
    set_ra_all(30);
    #3;
    chk("oor stored rd", rd2[XLEN-1:0], 0);
    chk("oor busy", 32'(rd_busy2), 0);
    chk("r30 full file rd", rd[XLEN-1:0], 32'h00000BAD);
    chk("r30 full file busy", 32'(rd_busy[0]), 1);
    set_ra_all(5);
    #1;
    chk("in-range rd 24-entry", rd2[XLEN-1:0], exp_rd(5));
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      we = 2'($urandom);
      for (int i = 0; i < NWR; i++) begin
        wa[i*AW +: AW] = AW'($urandom_range(0, 7));
        wd[i*XLEN +: XLEN] = $urandom;
      end
      for (int k = 0; k < NRD; k++)
        ra[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      hilo_we = 2'($urandom); hi_wd = $urandom; lo_wd = $urandom;
      iss_valid = 1'($urandom); iss_dst = AW'($urandom_range(0, 7));
      iss_gpr = 1'($urandom); iss_hilo = 1'($urandom);
      flush = ($urandom_range(0, 15) == 0);
      #3;
      check_model($sformatf("rand%0d", c));
      tick();
    end

    // Asynchronous reset between edges
    idle();
    we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'h0, 32'h55};
    iss_valid = 1; iss_gpr = 1; iss_dst = 3;
    #3;
    tick();
    idle();
    set_ra_all(3);
    #3;
    chk("pre-reset r3", rd[XLEN-1:0], 32'h55);
    chk("pre-reset busy3", 32'(rd_busy[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("async reset rd", rd[XLEN-1:0], 0);
    chk("async reset rd_busy", 32'(rd_busy), 0);
    we = 2'b01; wa = {5'd0, 5'd4}; wd = {32'h0, 32'h44};
    hilo_we = 2'b11; hi_wd = 32'h1; lo_wd = 32'h2;
    iss_valid = 1; iss_hilo = 1;
    set_ra_all(4);
    #1;
    chk("in-reset bypass rd", rd[XLEN-1:0], 0);
    chk("in-reset hi", hi_rd, 0);
    chk("in-reset hilo_busy", 32'(hilo_busy), 0);
    @(posedge clk);
    model_reset();
    #2;
    rst = 1'b0;
    hilo_we = 0; iss_valid = 0; iss_hilo = 0;
    #2;
    chk("post-reset bypass r4", rd[XLEN-1:0], 32'h44);
    tick();
    idle();
    set_ra_all(4);
    #3;
    chk("post-reset stored r4", rd[XLEN-1:0], 32'h44);
    set_ra_all(3);
    #1;
    chk("post-reset r3 cleared", rd[XLEN-1:0], 0);
    chk("post-reset busy3 cleared", 32'(rd_busy[0]), 0);
    chk("post-reset hi", hi_rd, 0);
    chk("post-reset hilo_busy", 32'(hilo_busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL expose parameter XLEN, default 32, data width of GPRs, HI and LO.
REQ-002 SHALL expose parameter NREG, default 32, number of GPRs; index width AW = clog2(NREG).
REQ-003 SHALL expose parameter NRD, default 4, number of GPR read ports.
REQ-004 SHALL expose parameter NWR, default 2, number of GPR write ports.
REQ-005 Ports, one per line: name  direction  width  meaning:
  clk  in  1  single clock, rising edge active
  rst  in  1  reset, asynchronous, active-high
  ra  in  NRD x AW  read addresses
  rd  out  NRD x XLEN  read data
  rd_busy  out  NRD  read register has an outstanding write
  we  in  NWR  GPR write enables
  wa  in  NWR x AW  GPR write addresses
  wd  in  NWR x XLEN  GPR write data
  hilo_we  in  2  bit1 = write HI, bit0 = write LO
  hi_wd, lo_wd  in  XLEN each  HI / LO write data
  hi_rd, lo_rd  out  XLEN each  HI / LO read data
  hilo_busy  out  1  HI/LO has an outstanding write
  iss_valid  in  1  an instruction issues this cycle
  iss_dst  in  AW  GPR destination of the issuing instruction
  iss_gpr  in  1  issuing instruction writes a GPR
  iss_hilo  in  1  issuing instruction writes HI and/or LO
  flush  in  1  discard all outstanding-write marks

Function
REQ-006 GPR and HI/LO writes SHALL occur on the rising clk edge.
REQ-007 Register 0 SHALL always read 0; writes and issue marks to index 0 SHALL be ignored.
REQ-008 Reads SHALL be combinational; a write to the read address in the same cycle SHALL be forwarded to rd (write-through bypass, zero latency).
REQ-009 When several write ports target the same address in one cycle, the highest-indexed port SHALL win for both storage and bypass.
REQ-010 HI and LO SHALL be written independently per hilo_we bit; hi_rd/lo_rd SHALL bypass same-cycle hi_wd/lo_wd.
REQ-011 Scoreboard: one busy bit per GPR plus one HI/LO busy bit, all in register state.
REQ-012 iss_valid & iss_gpr SHALL set busy[iss_dst] at the next edge; iss_valid & iss_hilo SHALL set the HI/LO bit.
REQ-013 Any we[i] SHALL clear busy[wa[i]] at the next edge; any hilo_we bit SHALL clear the HI/LO bit.
REQ-014 Simultaneous set and clear of the same bit SHALL leave it set (new issue dominates retiring write).
REQ-015 rd_busy[k] SHALL equal busy[ra[k]] AND NOT (any we[i] with wa[i]==ra[k]); hilo_busy SHALL be the HI/LO bit AND NOT |hilo_we.
REQ-016 flush SHALL clear all busy bits at the next edge and SHALL take priority over same-cycle issue sets; same-cycle writes SHALL still update data.
REQ-017 Out-of-range addresses (index >= NREG when NREG < 2^AW) SHALL read 0, SHALL never report busy, and writes to them SHALL be ignored.

Reset
REQ-018 rst asserted SHALL immediately clear all GPRs, HI, LO and all busy bits, independent of clk.
REQ-019 During reset all rd, hi_rd, lo_rd SHALL be 0 and all busy outputs 0; inputs sampled during reset SHALL have no effect.
REQ-020 A reset asserted mid-operation SHALL discard in-flight issue marks; first write takes effect on the first rising edge after deassertion.

Structure
REQ-021 Package regfile_pkg SHALL hold default XLEN/NREG constants and the register-index typedef shared with decode and writeback.
REQ-022 The busy bitmap and its set/clear/flush priority logic SHALL live in one sub-module, regfile_scoreboard.

Verification
REQ-023 Reset then write wa[0]=5, wd=0xDEADBEEF; same-cycle ra[0]=5 -> rd[0]=0xDEADBEEF; next cycle still 0xDEADBEEF.
REQ-024 we[0] and we[1] both to r7 with 0x1111 / 0x2222 -> bypass and stored value 0x2222.
REQ-025 Write r0 = 0xFFFFFFFF, issue dst=0 -> rd=0, rd_busy=0.
REQ-026 Issue dst=9; next cycle rd_busy=1 for ra=9; write r9 that cycle -> rd_busy=0 same cycle, busy bit cleared next edge; simultaneous issue dst=9 + write r9 -> bit stays 1.
REQ-027 hilo_we=2'b10, hi_wd=0xA5A5 -> hi_rd=0xA5A5, lo_rd unchanged; issue iss_hilo then flush -> hilo_busy=0 next cycle.
REQ-028 Assert rst asynchronously between edges while r3=0x55 and busy[3]=1 -> rd=0 and rd_busy=0 immediately.
